// File: rtl/chip8_pkg.sv
// Shared keypad definitions: physical matrix position to CHIP-8 key value,
// wait-FSM state encoding and a lowest-set-bit helper.
package chip8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_ACK
    } wait_state_t;

    // Indexed by row*4+col; row0 = 1 2 3 C, row1 = 4 5 6 D, row2 = 7 8 9 E, row3 = A 0 B F.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hF, 4'hB, 4'h0, 4'hA,
        4'hE, 4'h9, 4'h8, 4'h7,
        4'hD, 4'h6, 4'h5, 4'h4,
        4'hC, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/chip8_debounce.sv
// Per-key debouncer: flips state after DEBOUNCE_N consecutive frames whose
// raw value differs from the current state; any agreeing frame restarts the count.
module chip8_debounce #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic state
);
    localparam int CW = $clog2(DEBOUNCE_N + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (en) begin
            if (raw == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEBOUNCE_N - 1)) begin
                cnt_d   = '0;
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/chip8_keypad.sv
// 4x4 matrix keypad scanner with per-key debounce and an FX0A-style
// press-and-release capture handshake (four-phase wait_req/wait_ack).
module chip8_keypad
    import chip8_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  col_out,
    input  logic [3:0]  row_in,
    output logic [15:0] key_state,
    input  logic        wait_req,
    output logic        wait_ack,
    output logic [3:0]  wait_key
);
    localparam int DW = $clog2(SCAN_DIV + 1);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_q, col_d;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   frame_phys;
    logic [15:0]   frame_key;
    logic          last_cyc;
    logic          frame_stb;

    assign last_cyc  = (div_q == DW'(SCAN_DIV - 1));
    assign frame_stb = last_cyc && (col_q == 2'd3);
    assign col_out   = ~(4'b0001 << col_q);

    always_comb begin
        div_d  = last_cyc ? '0 : div_q + 1'b1;
        col_d  = last_cyc ? col_q + 2'd1 : col_q;
        snap_d = snap_q;
        if (last_cyc) begin
            for (int r = 0; r < 4; r++) snap_d[r*4 + int'(col_q)] = ~row_in[r];
        end
    end

    // Column 3 is taken straight from the rows so the frame is complete on its sample cycle.
    always_comb begin
        frame_phys = snap_q;
        for (int r = 0; r < 4; r++) frame_phys[r*4 + 3] = ~row_in[r];
        frame_key = '0;
        for (int p = 0; p < 16; p++) frame_key[KEY_MAP[p]] = frame_phys[p];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            col_q  <= '0;
            snap_q <= '0;
        end else begin
            div_q  <= div_d;
            col_q  <= col_d;
            snap_q <= snap_d;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_db
        chip8_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db (
            .clk   (clk),
            .rst   (rst),
            .en    (frame_stb),
            .raw   (frame_key[k]),
            .state (key_state[k])
        );
    end

    wait_state_t state_q;
    logic        wait_ack_q;
    logic [3:0]  wait_key_q;

    // Dropping wait_req aborts a pending capture before any key event is considered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_ack_q <= 1'b0;
            wait_key_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wait_req) state_q <= ST_WAIT_PRESS;
                end
                ST_WAIT_PRESS: begin
                    if (!wait_req) begin
                        state_q <= ST_IDLE;
                    end else if (|key_state) begin
                        wait_key_q <= lowest_set(key_state);
                        state_q    <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!wait_req) begin
                        state_q <= ST_IDLE;
                    end else if (!key_state[wait_key_q]) begin
                        state_q    <= ST_ACK;
                        wait_ack_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!wait_req) begin
                        state_q    <= ST_IDLE;
                        wait_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wait_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign wait_ack = wait_ack_q;
    assign wait_key = wait_key_q;

endmodule

// File: tb/tb_chip8_keypad.sv
// Directed bench for chip8_keypad with a behavioural key matrix (SCAN_DIV=4, DEBOUNCE_N=3).
module tb_chip8_keypad;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic [15:0] key_state;
    logic        wait_req;
    logic        wait_ack;
    logic [3:0]  wait_key;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;

    chip8_keypad #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_out   (col_out),
        .row_in    (row_in),
        .key_state (key_state),
        .wait_req  (wait_req),
        .wait_ack  (wait_ack),
        .wait_key  (wait_key)
    );

    always #5 clk = ~clk;

    // pressed[] is indexed by row*4+col; a row reads low when a pressed key sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
    end

    // Leaves the bench at the negedge inside the column-3 sample cycle.
    task automatic sync_frame_end;
        logic [3:0] prev;
        int n;
        prev = col_out;
        n = 0;
        @(negedge clk);
        while (!(col_out == 4'b0111 && prev != 4'b0111) && n < 64) begin
            prev = col_out;
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            checks++; errors++;
            $display("FAIL sync_timeout: col_out=%b never entered column 3", col_out);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; wait_req = 1'b0; pressed = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col_out); end
        checks++;
        if (key_state !== 16'h0000) begin errors++; $display("FAIL reset_keys: got %h want 0000", key_state); end
        checks++;
        if (wait_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", wait_ack); end
        checks++;
        if (wait_key !== 4'h0) begin errors++; $display("FAIL reset_key: got %h want 0", wait_key); end
        rst = 1'b0;
    endtask

    task automatic test_scan;
        logic [3:0] exp;
        for (int k = 0; k < 20; k++) begin
            exp = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (col_out !== exp) begin errors++; $display("FAIL scan_col%0d: got %b want %b", k, col_out, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_stable_press;
        sync_frame_end;
        pressed[5] = 1'b1;
        repeat (48) @(negedge clk);
        checks++;
        if (key_state !== 16'h0000) begin errors++; $display("FAIL press_early: got %h want 0000", key_state); end
        @(negedge clk);
        checks++;
        if (key_state !== 16'h0020) begin errors++; $display("FAIL press_key5: got %h want 0020", key_state); end
        sync_frame_end;
        pressed[5] = 1'b0;
        repeat (49) @(negedge clk);
        checks++;
        if (key_state !== 16'h0000) begin errors++; $display("FAIL release_key5: got %h want 0000", key_state); end
    endtask

    task automatic test_bounce;
        logic seen;
        seen = 1'b0;
        sync_frame_end;
        pressed[5] = 1'b1;
        repeat (32) @(negedge clk);
        pressed[5] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (key_state != 16'h0000) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL bounce: key_state went nonzero, want 0000 throughout"); end
    endtask

    task automatic test_simultaneous;
        wait_req = 1'b1;
        sync_frame_end;
        pressed[10] = 1'b1;
        pressed[2]  = 1'b1;
        repeat (49) @(negedge clk);
        checks++;
        if (key_state !== 16'h0208) begin errors++; $display("FAIL simul_keys: got %h want 0208", key_state); end
        @(negedge clk);
        checks++;
        if (wait_key !== 4'h3) begin errors++; $display("FAIL simul_capture: got %h want 3", wait_key); end
        sync_frame_end;
        pressed[10] = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (key_state !== 16'h0008) begin errors++; $display("FAIL simul_rel9_keys: got %h want 0008", key_state); end
        checks++;
        if (wait_ack !== 1'b0) begin errors++; $display("FAIL simul_rel9_ack: got %b want 0", wait_ack); end
        sync_frame_end;
        pressed[2] = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (wait_ack !== 1'b1) begin errors++; $display("FAIL simul_rel3_ack: got %b want 1", wait_ack); end
        checks++;
        if (wait_key !== 4'h3) begin errors++; $display("FAIL simul_rel3_key: got %h want 3", wait_key); end
        wait_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wait_ack !== 1'b0) begin errors++; $display("FAIL simul_drop: got %b want 0", wait_ack); end
    endtask

    task automatic test_wait_handshake;
        wait_req = 1'b1;
        sync_frame_end;
        pressed[13] = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (key_state !== 16'h0001) begin errors++; $display("FAIL hs_press_keys: got %h want 0001", key_state); end
        checks++;
        if (wait_key !== 4'h0) begin errors++; $display("FAIL hs_capture: got %h want 0", wait_key); end
        sync_frame_end;
        pressed[13] = 1'b0;
        repeat (48) @(negedge clk);
        checks++;
        if (wait_ack !== 1'b0) begin errors++; $display("FAIL hs_ack_early: got %b want 0", wait_ack); end
        @(negedge clk);
        checks++;
        if (wait_ack !== 1'b0) begin errors++; $display("FAIL hs_ack_release_cycle: got %b want 0", wait_ack); end
        @(negedge clk);
        checks++;
        if (wait_ack !== 1'b1) begin errors++; $display("FAIL hs_ack: got %b want 1", wait_ack); end
        checks++;
        if (wait_key !== 4'h0) begin errors++; $display("FAIL hs_key: got %h want 0", wait_key); end
        repeat (10) @(negedge clk);
        checks++;
        if (wait_ack !== 1'b1) begin errors++; $display("FAIL hs_ack_hold: got %b want 1", wait_ack); end
        wait_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wait_ack !== 1'b0) begin errors++; $display("FAIL hs_ack_drop: got %b want 0", wait_ack); end
    endtask

    task automatic test_abort_release;
        logic seen;
        seen = 1'b0;
        wait_req = 1'b1;
        sync_frame_end;
        pressed[12] = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (wait_key !== 4'hA) begin errors++; $display("FAIL abort_capture: got %h want a", wait_key); end
        wait_req = 1'b0;
        @(negedge clk);
        pressed[12] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (wait_ack) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_noack: wait_ack asserted, want 0 throughout"); end
        checks++;
        if (key_state !== 16'h0000) begin errors++; $display("FAIL abort_keys: got %h want 0000", key_state); end
    endtask

    task automatic test_abort_reset;
        logic seen;
        seen = 1'b0;
        sync_frame_end;
        pressed[15] = 1'b1;
        repeat (49) @(negedge clk);
        checks++;
        if (key_state !== 16'h8000) begin errors++; $display("FAIL rstabort_keys: got %h want 8000", key_state); end
        wait_req = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (key_state !== 16'h0000) begin errors++; $display("FAIL rstabort_clear: got %h want 0000", key_state); end
        checks++;
        if (wait_key !== 4'h0) begin errors++; $display("FAIL rstabort_key: got %h want 0", wait_key); end
        checks++;
        if (col_out !== 4'b1110) begin errors++; $display("FAIL rstabort_col: got %b want 1110", col_out); end
        wait_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wait_ack) seen = 1'b1;
        end
        pressed[15] = 1'b0;
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rstabort_noack: wait_ack asserted, want 0 throughout"); end
        checks++;
        if (key_state !== 16'h8000) begin errors++; $display("FAIL rstabort_redebounce: got %h want 8000", key_state); end
    endtask

    initial begin
        rst = 1'b1;
        wait_req = 1'b0;
        pressed = '0;
        @(negedge clk);
        test_reset;
        test_scan;
        test_stable_press;
        test_bounce;
        test_simultaneous;
        test_wait_handshake;
        test_abort_release;
        test_abort_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
